// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// instruction field constants and ALU operation codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'd0,
        ALUOP_ADD   = 2'd1,
        ALUOP_SUB   = 2'd2,
        ALUOP_FUNCT = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    function automatic logic is_rtype_funct(input logic [5:0] f);
        return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's ALU request and the funct field
// to a 4-bit ALU operation code.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_AND;
        unique case (aluop)
            ALUOP_NONE: alucontrol = ALU_AND;
            ALUOP_ADD:  alucontrol = ALU_ADD;
            ALUOP_SUB:  alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch,
// decode, memory, ALU, branch and jump steps.
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit EN_BNE    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic [3:0]           state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       r_bne;
    aluop_t     w_aluop;
    logic       w_pcen;
    logic       w_irwrite;
    logic [3:0] w_alu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_bne   <= 1'b0;
        end else begin
            r_state <= w_next;
            // Branch flavour is captured here so BRANCH never looks at op
            if (r_state == S_DECODE)
                r_bne <= (op == OP_BNE);
        end
    end

    always_comb begin
        w_next    = r_state;
        memread   = 1'b0;
        memwrite  = 1'b0;
        iord      = 1'b0;
        w_irwrite = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        w_pcen    = 1'b0;
        w_aluop   = ALUOP_NONE;
        case (r_state)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                w_aluop   = ALUOP_ADD;
                w_irwrite = mem_ready;
                w_pcen    = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                w_aluop = ALUOP_ADD;
                unique case (1'b1)
                    (op == OP_LW) || (op == OP_SW):
                        w_next = S_MEMADR;
                    (op == OP_RTYPE) && is_rtype_funct(funct):
                        w_next = S_EXECUTE;
                    (op == OP_BEQ) || (EN_BNE && (op == OP_BNE)):
                        w_next = S_BRANCH;
                    (op == OP_ADDI):
                        w_next = S_ADDIEX;
                    (op == OP_J):
                        w_next = S_JUMP;
                    default:
                        w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = ALUOP_ADD;
                if (op == OP_SW)
                    w_next = S_MEMWR;
                else if (op == OP_LW)
                    w_next = S_MEMRD;
                else
                    w_next = S_ILLEGAL;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready)
                    w_next = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_SUB;
                pcsrc   = 2'b01;
                w_pcen  = r_bne ? ~zero : zero;
                w_next  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_aluop = ALUOP_ADD;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = 2'b10;
                w_pcen = 1'b1;
                w_next = S_FETCH;
            end
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .funct      (funct),
        .aluop      (w_aluop),
        .alucontrol (w_alu)
    );

    // FETCH is the reset state, so its mem_ready-driven enables are gated
    assign pcen       = w_pcen & reset;
    assign irwrite    = w_irwrite & reset;
    assign alucontrol = ALUCTRL_W'(w_alu);
    assign illegal    = (r_state == S_ILLEGAL);
    assign state_o    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: one task per instruction class,
// reset behaviour and the bne-disabled variant.
module tb_mc_controller;

    localparam logic [3:0] SF  = 4'd0,  SD  = 4'd1,  SMA = 4'd2;
    localparam logic [3:0] SMR = 4'd3,  SMB = 4'd4,  SMW = 4'd5;
    localparam logic [3:0] SEX = 4'd6,  SAW = 4'd7,  SBR = 4'd8;
    localparam logic [3:0] SAE = 4'd9,  SAB = 4'd10, SJ  = 4'd11;
    localparam logic [3:0] SIL = 4'd12;

    // {memread,memwrite,iord,irwrite, regdst,memtoreg,regwrite,alusrca,
    //  alusrcb, pcsrc, pcen}
    localparam logic [12:0] CF1  = 13'b1001_0000_01_00_1;
    localparam logic [12:0] CF0  = 13'b1000_0000_01_00_0;
    localparam logic [12:0] CD   = 13'b0000_0000_11_00_0;
    localparam logic [12:0] CMA  = 13'b0000_0001_10_00_0;
    localparam logic [12:0] CMR  = 13'b1010_0000_00_00_0;
    localparam logic [12:0] CMB  = 13'b0000_0110_00_00_0;
    localparam logic [12:0] CMW  = 13'b0110_0000_00_00_0;
    localparam logic [12:0] CEX  = 13'b0000_0001_00_00_0;
    localparam logic [12:0] CAW  = 13'b0000_1010_00_00_0;
    localparam logic [12:0] CAE  = 13'b0000_0001_10_00_0;
    localparam logic [12:0] CAB  = 13'b0000_0010_00_00_0;
    localparam logic [12:0] CJ   = 13'b0000_0000_00_10_1;
    localparam logic [12:0] CBR0 = 13'b0000_0001_00_01_0;
    localparam logic [12:0] CBR1 = 13'b0000_0001_00_01_1;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;

    logic clk = 1'b0;
    logic reset, zero, mem_ready;
    logic [5:0] op, funct;

    logic memread0, memwrite0, iord0, irwrite0, regdst0, memtoreg0;
    logic regwrite0, alusrca0, pcen0, illegal0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [3:0] alu0, state0;
    logic [12:0] ctl0;

    logic memread1, memwrite1, iord1, irwrite1, regdst1, memtoreg1;
    logic regwrite1, alusrca1, pcen1, illegal1;
    logic [1:0] alusrcb1, pcsrc1;
    logic [5:0] alu1;
    logic [3:0] state1;
    logic [12:0] ctl1;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    mc_controller u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .memread(memread0), .memwrite(memwrite0), .iord(iord0),
        .irwrite(irwrite0), .regdst(regdst0), .memtoreg(memtoreg0),
        .regwrite(regwrite0), .alusrca(alusrca0), .alusrcb(alusrcb0),
        .pcsrc(pcsrc0), .pcen(pcen0), .alucontrol(alu0),
        .illegal(illegal0), .state_o(state0)
    );

    mc_controller #(.ALUCTRL_W(6), .EN_BNE(1'b0)) u_nobne (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .memread(memread1), .memwrite(memwrite1), .iord(iord1),
        .irwrite(irwrite1), .regdst(regdst1), .memtoreg(memtoreg1),
        .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
        .pcsrc(pcsrc1), .pcen(pcen1), .alucontrol(alu1),
        .illegal(illegal1), .state_o(state1)
    );

    assign ctl0 = {memread0, memwrite0, iord0, irwrite0, regdst0,
                   memtoreg0, regwrite0, alusrca0, alusrcb0, pcsrc0, pcen0};
    assign ctl1 = {memread1, memwrite1, iord1, irwrite1, regdst1,
                   memtoreg1, regwrite1, alusrca1, alusrcb1, pcsrc1, pcen1};

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        op = RT; funct = 6'd0;
        #1;
        vec++;
        if (state0 !== SF || illegal0 !== 1'b0) begin
            err++;
            $display("FAIL reset_state got %0d/%b exp 0/0", state0, illegal0);
        end
        vec++;
        if (pcen0 !== 1'b0 || irwrite0 !== 1'b0 || memwrite0 !== 1'b0
            || regwrite0 !== 1'b0) begin
            err++;
            $display("FAIL reset_we got pcen=%b irw=%b mw=%b rw=%b exp 0",
                     pcen0, irwrite0, memwrite0, regwrite0);
        end
        #6;
        vec++;
        if (state0 !== SF) begin
            err++;
            $display("FAIL reset_hold got %0d exp 0", state0);
        end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0]  st [6];
        logic [12:0] ct [6];
        logic [3:0]  al [6];
        logic        rd [6];
        st = '{SF, SD, SMA, SMR, SMB, SF};
        ct = '{CF1, CD, CMA, CMR, CMB, CF0};
        al = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        op = LW;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ready = rd[i]; #1;
            vec++;
            if (state0 !== st[i]) begin
                err++;
                $display("FAIL lw_state[%0d] got %0d exp %0d", i, state0, st[i]);
            end
            vec++;
            if (ctl0 !== ct[i]) begin
                err++;
                $display("FAIL lw_ctl[%0d] got %b exp %b", i, ctl0, ct[i]);
            end
            vec++;
            if (alu0 !== al[i]) begin
                err++;
                $display("FAIL lw_alu[%0d] got %b exp %b", i, alu0, al[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [3:0]  st [8];
        logic [12:0] ct [8];
        logic [3:0]  al [8];
        logic        rd [8];
        st = '{SF, SD, SMA, SMW, SMW, SMW, SMW, SF};
        ct = '{CF1, CD, CMA, CMW, CMW, CMW, CMW, CF0};
        al = '{4'b0010, 4'b0010, 4'b0010, 4'b0000,
               4'b0000, 4'b0000, 4'b0000, 4'b0010};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = SW;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); mem_ready = rd[i]; #1;
            vec++;
            if (state0 !== st[i]) begin
                err++;
                $display("FAIL sw_state[%0d] got %0d exp %0d", i, state0, st[i]);
            end
            vec++;
            if (ctl0 !== ct[i]) begin
                err++;
                $display("FAIL sw_ctl[%0d] got %b exp %b", i, ctl0, ct[i]);
            end
            vec++;
            if (alu0 !== al[i]) begin
                err++;
                $display("FAIL sw_alu[%0d] got %b exp %b", i, alu0, al[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5];
        logic [3:0]  code [5];
        logic [3:0]  st [5];
        logic [12:0] ct [5];
        logic [3:0]  al [5];
        logic        rd [5];
        fn   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        code = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        st = '{SF, SD, SEX, SAW, SF};
        ct = '{CF1, CD, CEX, CAW, CF0};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        op = RT;
        for (int k = 0; k < 5; k++) begin
            funct = fn[k];
            al = '{4'b0010, 4'b0010, code[k], 4'b0000, 4'b0010};
            for (int i = 0; i < 5; i++) begin
                @(negedge clk); mem_ready = rd[i]; #1;
                vec++;
                if (state0 !== st[i]) begin
                    err++;
                    $display("FAIL rt%0d_state[%0d] got %0d exp %0d",
                             k, i, state0, st[i]);
                end
                vec++;
                if (ctl0 !== ct[i]) begin
                    err++;
                    $display("FAIL rt%0d_ctl[%0d] got %b exp %b",
                             k, i, ctl0, ct[i]);
                end
                vec++;
                if (alu0 !== al[i]) begin
                    err++;
                    $display("FAIL rt%0d_alu[%0d] got %b exp %b",
                             k, i, alu0, al[i]);
                end
                vec++;
                if (alu1 !== {2'b00, al[i]}) begin
                    err++;
                    $display("FAIL rt%0d_alu6[%0d] got %b exp %b",
                             k, i, alu1, {2'b00, al[i]});
                end
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0]  st [5];
        logic [12:0] ct [5];
        logic [3:0]  al [5];
        logic        rd [5];
        st = '{SF, SD, SAE, SAB, SF};
        ct = '{CF1, CD, CAE, CAB, CF0};
        al = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        op = ADDI;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = rd[i]; #1;
            vec++;
            if (state0 !== st[i] || ctl0 !== ct[i] || alu0 !== al[i]) begin
                err++;
                $display("FAIL addi[%0d] got %0d/%b/%b exp %0d/%b/%b",
                         i, state0, ctl0, alu0, st[i], ct[i], al[i]);
            end
        end
    endtask

    task automatic test_jump();
        logic [3:0]  st [4];
        logic [12:0] ct [4];
        logic [3:0]  al [4];
        logic        rd [4];
        st = '{SF, SD, SJ, SF};
        ct = '{CF1, CD, CJ, CF0};
        al = '{4'b0010, 4'b0010, 4'b0000, 4'b0010};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        op = JMP;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = rd[i]; #1;
            vec++;
            if (state0 !== st[i] || ctl0 !== ct[i] || alu0 !== al[i]) begin
                err++;
                $display("FAIL jump[%0d] got %0d/%b/%b exp %0d/%b/%b",
                         i, state0, ctl0, alu0, st[i], ct[i], al[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0]  bop [4];
        logic        bz [4];
        logic        bp [4];
        logic [3:0]  st [4];
        logic [12:0] ct [4];
        logic [3:0]  al [4];
        logic        rd [4];
        bop = '{BEQ, BEQ, BNE, BNE};
        bz  = '{1'b1, 1'b0, 1'b1, 1'b0};
        bp  = '{1'b1, 1'b0, 1'b0, 1'b1};
        st = '{SF, SD, SBR, SF};
        al = '{4'b0010, 4'b0010, 4'b0110, 4'b0010};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            op = bop[k]; zero = bz[k];
            ct = '{CF1, CD, (bp[k] ? CBR1 : CBR0), CF0};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); mem_ready = rd[i]; #1;
                vec++;
                if (state0 !== st[i] || ctl0 !== ct[i] || alu0 !== al[i]) begin
                    err++;
                    $display("FAIL br%0d[%0d] got %0d/%b/%b exp %0d/%b/%b",
                             k, i, state0, ctl0, alu0, st[i], ct[i], al[i]);
                end
            end
            if (bop[k] == BNE) begin
                vec++;
                if (state1 !== SIL || illegal1 !== 1'b1 || ctl1 !== 13'd0) begin
                    err++;
                    $display("FAIL nobne%0d got %0d/%b/%b exp 12/1/0",
                             k, state1, illegal1, ctl1);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal();
        op = RT; funct = 6'b000011;
        @(negedge clk); mem_ready = 1'b1; #1;
        @(negedge clk); #1;
        vec++;
        if (state0 !== SD) begin
            err++;
            $display("FAIL ill_decode got %0d exp 1", state0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); op = (i > 2) ? LW : RT; #1;
            vec++;
            if (state0 !== SIL || illegal0 !== 1'b1 || ctl0 !== 13'd0) begin
                err++;
                $display("FAIL ill_hold[%0d] got %0d/%b/%b exp 12/1/0",
                         i, state0, illegal0, ctl0);
            end
        end
        #2 reset = 1'b0; #1;
        vec++;
        if (state0 !== SF || illegal0 !== 1'b0
            || state1 !== SF || illegal1 !== 1'b0) begin
            err++;
            $display("FAIL ill_reset got %0d/%b %0d/%b exp 0/0 0/0",
                     state0, illegal0, state1, illegal1);
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [3:0]  st [4];
        logic        rd [4];
        st = '{SF, SD, SMA, SMW};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; op = SW; funct = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = rd[i]; #1;
            vec++;
            if (state0 !== st[i]) begin
                err++;
                $display("FAIL rmw_state[%0d] got %0d exp %0d", i, state0, st[i]);
            end
        end
        vec++;
        if (memwrite0 !== 1'b1) begin
            err++;
            $display("FAIL rmw_mw_before got %b exp 1", memwrite0);
        end
        #2 reset = 1'b0; mem_ready = 1'b1; #1;
        vec++;
        if (state0 !== SF || memwrite0 !== 1'b0
            || pcen0 !== 1'b0 || irwrite0 !== 1'b0) begin
            err++;
            $display("FAIL rmw_async got %0d mw=%b pcen=%b irw=%b exp 0 0 0 0",
                     state0, memwrite0, pcen0, irwrite0);
        end
        @(negedge clk); #1;
        vec++;
        if (state0 !== SF || irwrite0 !== 1'b0) begin
            err++;
            $display("FAIL rmw_held got %0d irw=%b exp 0 0", state0, irwrite0);
        end
        reset = 1'b1; #1;
        vec++;
        if (state0 !== SF || ctl0 !== CF1) begin
            err++;
            $display("FAIL rmw_fetch got %0d/%b exp 0/%b", state0, ctl0, CF1);
        end
        @(negedge clk); #1;
        vec++;
        if (state0 !== SD) begin
            err++;
            $display("FAIL rmw_decode got %0d exp 1", state0);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_jump();
        test_branch();
        test_illegal();
        test_reset_mid_memwr();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 4, width of alucontrol; SHALL be >= 4.
REQ-002 Parameter EN_BNE, default 1; 1 = bne (op 000101) supported, 0 = bne treated as illegal.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 op, funct  input  6 each  instruction fields from instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 memread, memwrite, iord, irwrite  output  1 each  memory/IR controls.
REQ-009 regdst, memtoreg, regwrite, alusrca  output  1 each  datapath selects and register write.
REQ-010 alusrcb  output  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
REQ-011 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 pcen  output  1  PC write enable.
REQ-013 alucontrol  output  ALUCTRL_W  ALU operation, zero-extended; codes and=0000, or=0001, add=0010, sub=0110, slt=0111.
REQ-014 illegal  output  1  sticky illegal-instruction flag.
REQ-015 state_o  output  4  current state, debug only.

Function
REQ-016 Moore FSM; every output except pcen and irwrite SHALL be a function of state only; any output not listed for a state SHALL be 0.
REQ-017 FETCH: memread=1, iord=0, alusrcb=01, add; irwrite=pcen=mem_ready; stay while mem_ready=0, else -> DECODE.
REQ-018 DECODE: alusrcb=11, add; -> MEMADR (lw 100011, sw 101011), EXECUTE (op 000000 with funct in {100000, 100010, 100100, 100101, 101010}), BRANCH (beq 000100; bne if EN_BNE), ADDIEX (001000), JUMP (000010), otherwise ILLEGAL.
REQ-019 MEMADR: alusrca=1, alusrcb=10, add; lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD: iord=1, memread=1; wait on mem_ready, then -> MEMWB. MEMWB: memtoreg=1, regwrite=1 -> FETCH.
REQ-021 MEMWR: iord=1, memwrite=1 held until the mem_ready cycle inclusive; then -> FETCH.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (add, sub, and, or, slt) -> ALUWB. ALUWB: regdst=1, regwrite=1 -> FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen = zero for beq, ~zero for bne; -> FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB: regwrite=1, regdst=0 -> FETCH.
REQ-025 JUMP: pcsrc=10, pcen=1 -> FETCH.
REQ-026 ILLEGAL: illegal=1, all write enables 0; state held until reset.
REQ-027 Instruction latencies: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3; each memory state adds one cycle per mem_ready=0 cycle.
REQ-028 op and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; changes elsewhere have no effect.

Reset
REQ-029 reset=0 SHALL force state FETCH and illegal=0 immediately, independent of clk, including mid-access in MEMRD/MEMWR.
REQ-030 During reset all write enables (memwrite, regwrite, irwrite, pcen) SHALL be 0; first FETCH begins on the first rising edge after reset releases.

Structure
REQ-031 Package mc_pkg SHALL hold the state enum (4-bit), opcode/funct constants, and alucontrol codes.
REQ-032 One combinational sub-module mc_aludec (funct, aluop -> alucontrol) SHALL be instantiated; the FSM remains in mc_controller.

Verification
REQ-033 Reset mid-MEMWR (mem_ready=0), then release -> memwrite=0 during reset, state_o=FETCH, first fetch follows.
REQ-034 lw with mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-035 sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; regwrite never 1.
REQ-036 beq zero=1 -> pcen=1 in BRANCH; bne zero=1 -> pcen=0; bne with EN_BNE=0 -> ILLEGAL.
REQ-037 R-type funct 100010 -> alucontrol=0110 in EXECUTE, regdst=1 in ALUWB; funct 000011 -> illegal=1, held across 10 cycles until reset.
